hazard_stall_ctrl: RTL

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

---
 rtl/hazard_stall_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, drain/halt handshake
// and saturating stall/flush performance counters.
module hazard_stall_ctrl #(
   parameter int unsigned DRAIN_CYCLES = 3,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             ex_memtoreg,
   input  logic             ex_regwr,
   input  logic [4:0]       ex_rw,
   input  logic             mem_branch_taken,
   input  logic             halt_req,
   input  logic             cnt_clr,
   output logic             pc_wr,
   output logic             ifid_wr,
   output logic             idex_bubble,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             halt_ack,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned DCW        = 3;
   localparam int unsigned DRAIN_LOAD = DRAIN_CYCLES - 1;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t         state;
   logic [DCW-1:0] drain_cnt;
   logic           load_use;
   logic           stall_evt;
   logic           flush_evt;

   // EX-stage load feeds a source the ID instruction actually reads
   assign load_use = ex_memtoreg && ex_regwr && (ex_rw != 5'd0) &&
                     ((id_uses_rs && (ex_rw == id_rs)) ||
                      (id_uses_rt && (ex_rw == id_rt)));

   // Pipeline-control outputs from registered state and current inputs
   always_comb begin
      pc_wr       = 1'b1;
      ifid_wr     = 1'b1;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      stall_evt   = 1'b0;
      flush_evt   = 1'b0;
      case (state)
         RUN: begin
            if (mem_branch_taken) begin
               ifid_flush  = 1'b1;
               idex_flush  = 1'b1;
               exmem_flush = 1'b1;
               flush_evt   = 1'b1;
            end else if (load_use) begin
               pc_wr       = 1'b0;
               ifid_wr     = 1'b0;
               idex_bubble = 1'b1;
               stall_evt   = 1'b1;
            end
         end
         DRAIN: begin
            // IF/ID holds the resume point; a late taken branch still redirects the PC
            pc_wr       = mem_branch_taken;
            ifid_wr     = 1'b0;
            idex_bubble = 1'b1;
            if (mem_branch_taken) begin
               ifid_flush  = 1'b1;
               idex_flush  = 1'b1;
               exmem_flush = 1'b1;
               flush_evt   = 1'b1;
            end
         end
         HALTED: begin
            pc_wr       = 1'b0;
            ifid_wr     = 1'b0;
            idex_bubble = 1'b1;
         end
         default: begin
            pc_wr   = 1'b1;
            ifid_wr = 1'b1;
         end
      endcase
   end

   // Drain/halt state machine with registered acknowledge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         drain_cnt <= '0;
         halt_ack  <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (halt_req) begin
                  state     <= DRAIN;
                  drain_cnt <= DCW'(DRAIN_LOAD);
               end
            end
            DRAIN: begin
               if (!halt_req) begin
                  state     <= RUN;
                  drain_cnt <= '0;
               end else if (drain_cnt == '0) begin
                  state    <= HALTED;
                  halt_ack <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt - DCW'(1);
               end
            end
            HALTED: begin
               if (!halt_req) begin
                  state    <= RUN;
                  halt_ack <= 1'b0;
               end
            end
            default: begin
               state     <= RUN;
               drain_cnt <= '0;
               halt_ack  <= 1'b0;
            end
         endcase
      end
   end

   // Saturating performance counters, clear wins over increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (cnt_clr) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule
